// File: rtl/stage_timer_if.sv
// Control/status bundle for stage_timer: the master drives run/clear/load/commit controls,
// and the slave returns BCD time, best time and status flags.
interface stage_timer_if;
   logic        run;
   logic        clear;
   logic        mode;
   logic        load;
   logic [6:0]  preset_min;
   logic [5:0]  preset_sec;
   logic        commit;
   logic [15:0] nums;
   logic [15:0] best_nums;
   logic        tick;
   logic        saturated;
   logic        expired;
   logic        new_best;

   modport master (
      output run, clear, mode, load, preset_min, preset_sec, commit,
      input  nums, best_nums, tick, saturated, expired, new_best
   );

   modport slave (
      input  run, clear, mode, load, preset_min, preset_sec, commit,
      output nums, best_nums, tick, saturated, expired, new_best
   );
endinterface

// File: rtl/stage_timer.sv
// Up/down mm:ss stage timer with best-time capture; tick is combinational, time updates on the tick edge,
// and the BCD outputs lag the time by one cycle. There is no backpressure: controls are sampled every cycle.
module stage_timer #(
   parameter int CLK_HZ  = 100000000,
   parameter int MAX_MIN = 99
) (
   input  logic         clk,
   input  logic         rst,
   stage_timer_if.slave bus
);

   localparam int             PW         = $clog2(CLK_HZ);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_HZ - 1);
   localparam logic [6:0]     MAX_M      = 7'(MAX_MIN);
   localparam logic [5:0]     SEC_LAST   = 6'd59;

   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(v / 7'd10);
      ones = 4'(v - 7'(tens) * 7'd10);
      return {tens, ones};
   endfunction

   function automatic logic [12:0] to_secs(input logic [6:0] m, input logic [5:0] s);
      return 13'(m) * 13'd60 + 13'(s);
   endfunction

   logic [PW-1:0] presc_q, presc_d;
   logic [6:0]    min_q, min_d;
   logic [5:0]    sec_q, sec_d;
   logic [6:0]    best_min_q, best_min_d;
   logic [5:0]    best_sec_q, best_sec_d;
   logic          sat_q, sat_d;
   logic          exp_q, exp_d;
   logic          new_best_q, new_best_d;
   logic [15:0]   nums_q, nums_d;
   logic [15:0]   best_nums_q, best_nums_d;

   logic          presc_wrap;
   logic          tick_int;
   logic          frozen;
   logic          better;
   logic [6:0]    min_load;
   logic [5:0]    sec_load;

   assign presc_wrap = (presc_q == PRESC_LAST);
   // Reset, clear and load all swallow a tick that would otherwise land in the same cycle.
   assign tick_int   = bus.run && presc_wrap && !rst && !bus.clear && !bus.load;
   assign frozen     = sat_q || exp_q;
   assign better     = to_secs(min_q, sec_q) < to_secs(best_min_q, best_sec_q);
   assign min_load   = (bus.preset_min > MAX_M) ? MAX_M : bus.preset_min;
   assign sec_load   = (bus.preset_sec > SEC_LAST) ? SEC_LAST : bus.preset_sec;

   always_comb begin
      presc_d    = presc_q;
      min_d      = min_q;
      sec_d      = sec_q;
      best_min_d = best_min_q;
      best_sec_d = best_sec_q;
      sat_d      = sat_q;
      exp_d      = exp_q;
      new_best_d = 1'b0;

      if (bus.run) begin
         presc_d = presc_wrap ? '0 : presc_q + PW'(1);
      end

      if (bus.clear) begin
         presc_d = '0;
         min_d   = '0;
         sec_d   = '0;
         sat_d   = 1'b0;
         exp_d   = 1'b0;
      end else if (bus.load) begin
         presc_d = '0;
         min_d   = min_load;
         sec_d   = sec_load;
         sat_d   = 1'b0;
         exp_d   = 1'b0;
      end else begin
         // Compare uses the registered (pre-tick) time even when a tick lands this cycle.
         if (bus.commit && !bus.mode && better) begin
            best_min_d = min_q;
            best_sec_d = sec_q;
            new_best_d = 1'b1;
         end

         if (tick_int && !frozen) begin
            if (!bus.mode) begin
               if (sec_q < SEC_LAST) begin
                  sec_d = sec_q + 6'd1;
               end else if (min_q < MAX_M) begin
                  sec_d = '0;
                  min_d = min_q + 7'd1;
               end else begin
                  sat_d = 1'b1;
               end
            end else begin
               if (sec_q != '0) begin
                  sec_d = sec_q - 6'd1;
                  if (min_q == '0 && sec_q == 6'd1) begin
                     exp_d = 1'b1;
                  end
               end else if (min_q != '0) begin
                  sec_d = SEC_LAST;
                  min_d = min_q - 7'd1;
               end else begin
                  exp_d = 1'b1;
               end
            end
         end
      end

      nums_d      = {to_bcd(min_q), to_bcd({1'b0, sec_q})};
      best_nums_d = {to_bcd(best_min_q), to_bcd({1'b0, best_sec_q})};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q     <= '0;
         min_q       <= '0;
         sec_q       <= '0;
         best_min_q  <= MAX_M;
         best_sec_q  <= SEC_LAST;
         sat_q       <= 1'b0;
         exp_q       <= 1'b0;
         new_best_q  <= 1'b0;
         nums_q      <= '0;
         best_nums_q <= {to_bcd(MAX_M), 8'h59};
      end else begin
         presc_q     <= presc_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         best_min_q  <= best_min_d;
         best_sec_q  <= best_sec_d;
         sat_q       <= sat_d;
         exp_q       <= exp_d;
         new_best_q  <= new_best_d;
         nums_q      <= nums_d;
         best_nums_q <= best_nums_d;
      end
   end

   assign bus.nums      = nums_q;
   assign bus.best_nums = best_nums_q;
   assign bus.tick      = tick_int;
   assign bus.saturated = sat_q;
   assign bus.expired   = exp_q;
   assign bus.new_best  = new_best_q;

   a_sec_range: assert property (@(posedge clk) disable iff (rst) sec_q <= SEC_LAST);
   a_min_range: assert property (@(posedge clk) disable iff (rst) min_q <= MAX_M);
   a_flags_excl: assert property (@(posedge clk) disable iff (rst) !(sat_q && exp_q));

endmodule

// File: tb/tb_stage_timer.sv
// Directed bench for stage_timer: driver queues expected per-tick and per-new_best results,
// monitors pop and compare when the DUT pulses tick or new_best.
`timescale 1ns/1ps
module tb_stage_timer;
   localparam int CLK_HZ  = 4;
   localparam int MAX_MIN = 2;

   typedef struct {
      logic [15:0] nums;
      logic        sat;
      logic        exp;
   } tick_exp_t;

   logic        clk = 1'b0;
   logic        rst;
   int          n_pass = 0;
   int          n_total = 0;
   tick_exp_t   tick_sb[$];
   logic [15:0] best_sb[$];

   always #5 clk = ~clk;

   stage_timer_if bus ();

   stage_timer #(.CLK_HZ(CLK_HZ), .MAX_MIN(MAX_MIN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   function automatic logic [15:0] bcd_time(input int secs);
      int m;
      int s;
      m = secs / 60;
      s = secs % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic push_tick(input int secs, input logic sat, input logic exp);
      tick_exp_t e;
      e.nums = bcd_time(secs);
      e.sat  = sat;
      e.exp  = exp;
      tick_sb.push_back(e);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int m, input int s);
      bus.preset_min = 7'(m);
      bus.preset_sec = 6'(s);
      bus.load = 1'b1;
      cyc(1);
      bus.load = 1'b0;
      cyc(2);
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      cyc(1);
      bus.clear = 1'b0;
      cyc(2);
   endtask

   task automatic do_commit();
      bus.commit = 1'b1;
      cyc(1);
      bus.commit = 1'b0;
   endtask

   task automatic run_ticks(input int n);
      int seen = 0;
      int waited = 0;
      bus.run = 1'b1;
      while (seen < n && waited < n * CLK_HZ + 8) begin
         @(negedge clk);
         waited++;
         if (bus.tick === 1'b1) seen++;
      end
      if (seen < n) begin
         n_total++;
         $display("FAIL run_ticks: saw %0d ticks, expected %0d", seen, n);
      end
      @(posedge clk);
      #1;
      bus.run = 1'b0;
      cyc(3);
   endtask

   // Per-tick monitor: flags one cycle after the tick, BCD time one cycle later.
   initial begin : tick_mon
      tick_exp_t e;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && bus.tick === 1'b1) begin
            if (tick_sb.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_tick at %0t", $time);
            end else begin
               e = tick_sb.pop_front();
               @(negedge clk);
               check("sat_after_tick", bus.saturated, e.sat);
               check("exp_after_tick", bus.expired, e.exp);
               @(negedge clk);
               check("nums_after_tick", bus.nums, e.nums);
            end
         end
      end
   end

   initial begin : best_mon
      logic [15:0] b;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && bus.new_best === 1'b1) begin
            if (best_sb.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_new_best at %0t best_nums 0x%0h", $time, bus.best_nums);
            end else begin
               b = best_sb.pop_front();
               @(negedge clk);
               check("best_nums_after_new_best", bus.best_nums, b);
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int pause_ticks;
      rst = 1'b1;
      bus.run = 1'b0;
      bus.clear = 1'b0;
      bus.mode = 1'b0;
      bus.load = 1'b0;
      bus.preset_min = '0;
      bus.preset_sec = '0;
      bus.commit = 1'b0;
      cyc(3);
      check("rst_nums", bus.nums, 16'h0000);
      check("rst_best_nums", bus.best_nums, 16'h0259);
      check("rst_tick", bus.tick, 1'b0);
      check("rst_saturated", bus.saturated, 1'b0);
      check("rst_expired", bus.expired, 1'b0);
      check("rst_new_best", bus.new_best, 1'b0);
      rst = 1'b0;

      // Count up for 20 cycles: tick on every fourth cycle.
      for (int i = 1; i <= 5; i++) push_tick(i, 1'b0, 1'b0);
      bus.run = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("tick_cadence", bus.tick, (i % 4 == 3));
      end
      @(posedge clk);
      #1;
      bus.run = 1'b0;
      cyc(3);
      check("nums_after_5_ticks", bus.nums, 16'h0005);

      // Saturation at 02:59.
      do_load(2, 55);
      for (int i = 176; i <= 179; i++) push_tick(i, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) push_tick(179, 1'b1, 1'b0);
      run_ticks(7);
      check("sat_held_nums", bus.nums, 16'h0259);
      check("sat_level", bus.saturated, 1'b1);
      do_clear();
      check("clear_nums", bus.nums, 16'h0000);
      check("clear_saturated", bus.saturated, 1'b0);

      // Count down 01:05 to expiry.
      bus.mode = 1'b1;
      do_load(1, 5);
      check("load_0105", bus.nums, 16'h0105);
      for (int i = 1; i <= 66; i++) push_tick((65 - i < 0) ? 0 : 65 - i, 1'b0, (i >= 65));
      run_ticks(66);
      check("expired_nums", bus.nums, 16'h0000);
      check("expired_level", bus.expired, 1'b1);
      do_load(0, 3);
      check("reload_expired", bus.expired, 1'b0);
      check("reload_nums", bus.nums, 16'h0003);
      do_load(0, 0);
      check("load_zero_not_expired", bus.expired, 1'b0);
      push_tick(0, 1'b0, 1'b1);
      run_ticks(1);
      check("zero_expires_on_tick", bus.expired, 1'b1);

      // Pause holds the prescaler count.
      bus.mode = 1'b0;
      do_clear();
      push_tick(1, 1'b0, 1'b0);
      bus.run = 1'b1;
      cyc(2);
      bus.run = 1'b0;
      pause_ticks = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.tick === 1'b1) pause_ticks++;
      end
      check("no_tick_paused", pause_ticks, 0);
      @(posedge clk);
      #1;
      bus.run = 1'b1;
      @(negedge clk);
      check("resume_cycle1_tick", bus.tick, 1'b0);
      @(negedge clk);
      check("resume_cycle2_tick", bus.tick, 1'b1);
      @(posedge clk);
      #1;
      bus.run = 1'b0;
      cyc(3);
      check("resume_nums", bus.nums, 16'h0001);

      // Best time capture.
      do_clear();
      for (int i = 1; i <= 7; i++) push_tick(i, 1'b0, 1'b0);
      run_ticks(7);
      best_sb.push_back(16'h0007);
      do_commit();
      check("new_best_pulse", bus.new_best, 1'b1);
      cyc(3);
      do_clear();
      check("clear_keeps_best", bus.best_nums, 16'h0007);
      for (int i = 1; i <= 9; i++) push_tick(i, 1'b0, 1'b0);
      run_ticks(9);
      do_commit();
      check("slower_no_new_best", bus.new_best, 1'b0);
      cyc(2);
      check("slower_best_kept", bus.best_nums, 16'h0007);
      do_load(0, 7);
      do_commit();
      check("equal_no_new_best", bus.new_best, 1'b0);
      cyc(2);

      // Commit on the tick cycle compares the pre-tick time (00:06, not 00:07).
      do_load(0, 6);
      push_tick(7, 1'b0, 1'b0);
      best_sb.push_back(16'h0006);
      bus.run = 1'b1;
      cyc(3);
      bus.commit = 1'b1;
      cyc(1);
      bus.commit = 1'b0;
      bus.run = 1'b0;
      cyc(3);
      check("tick_commit_best", bus.best_nums, 16'h0006);

      bus.mode = 1'b1;
      do_load(0, 3);
      do_commit();
      check("mode1_commit_ignored", bus.new_best, 1'b0);
      cyc(2);
      check("mode1_best_kept", bus.best_nums, 16'h0006);

      // Preset clamping.
      bus.mode = 1'b0;
      do_load(5, 63);
      check("clamp_both", bus.nums, 16'h0259);
      do_load(1, 60);
      check("clamp_sec", bus.nums, 16'h0159);
      do_load(2, 45);
      check("no_clamp", bus.nums, 16'h0245);

      // Reset mid-count beats load and commit.
      do_load(0, 2);
      bus.run = 1'b1;
      cyc(2);
      rst = 1'b1;
      bus.load = 1'b1;
      bus.commit = 1'b1;
      bus.preset_min = 7'd1;
      bus.preset_sec = 6'd30;
      cyc(1);
      rst = 1'b0;
      bus.load = 1'b0;
      bus.commit = 1'b0;
      bus.run = 1'b0;
      cyc(2);
      check("midrst_nums", bus.nums, 16'h0000);
      check("midrst_best_nums", bus.best_nums, 16'h0259);
      check("midrst_new_best", bus.new_best, 1'b0);
      push_tick(1, 1'b0, 1'b0);
      bus.run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("midrst_presc_restart", bus.tick, (i == 3));
      end
      @(posedge clk);
      #1;
      bus.run = 1'b0;
      cyc(5);

      check("tick_queue_drained", tick_sb.size(), 0);
      check("best_queue_drained", best_sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
